// File: rtl/axi_sram_if.sv
// AXI4 bus bundle between the TPU master port and the SRAM slave.
// Carries the AW/W/B write channels and the AR/R read channels.
// Modports: master drives requests/data and B/R ready; slave drives
// address/data ready, write responses and read data.
interface axi_sram_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ID_WIDTH-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ID_WIDTH-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output RREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by a single-port synchronous word array; one burst at a time.
// Ports: clk, rst (async, active-high), axi (slave modport: AW/W/B, AR/R).
// Writes sustain 1 beat/cycle; reads take 2 cycles/beat (array read, then R beat).
module axi_sram_slave #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_DEPTH  = 4096
) (
  input  logic         clk,
  input  logic         rst,
  axi_sram_if.slave    axi
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned WA_W   = ADDR_WIDTH - 3;
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA} state_t;

  state_t                 state, state_nxt;
  logic [ID_WIDTH-1:0]    id_q;
  logic [WA_W-1:0]        addr_q;
  logic [7:0]             len_q;
  logic [7:0]             beat_q;
  logic                   fixed_q;
  logic                   err_q;
  logic                   decerr_q;
  logic                   last_rd_q;
  logic [DATA_WIDTH-1:0]  mem_q;
  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  logic grant_w, aw_go, ar_go, w_hs, last_beat, in_range;

  // Request is malformed unless 8-byte beats and FIXED/INCR burst.
  function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd3) || burst[1];
  endfunction

  // Round-robin: write wins a tie only if read was served last.
  assign grant_w   = axi.AWVALID & (~axi.ARVALID | last_rd_q);
  assign aw_go     = ~rst & (state == IDLE) & axi.AWVALID & grant_w;
  assign ar_go     = ~rst & (state == IDLE) & axi.ARVALID & ~grant_w;
  assign w_hs      = (state == WR_DATA) & axi.WVALID;
  assign last_beat = (beat_q == len_q);
  assign in_range  = (addr_q < WA_W'(MEM_DEPTH));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and bus outputs, decoded from state and latched burst fields
  always_comb begin
    state_nxt   = state;
    axi.AWREADY = 1'b0;
    axi.ARREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BID     = '0;
    axi.BRESP   = 2'b00;
    axi.RVALID  = 1'b0;
    axi.RID     = '0;
    axi.RDATA   = '0;
    axi.RRESP   = 2'b00;
    axi.RLAST   = 1'b0;
    case (state)
      IDLE: begin
        axi.AWREADY = aw_go;
        axi.ARREADY = ar_go;
        if (aw_go)      state_nxt = WR_DATA;
        else if (ar_go) state_nxt = RD_REQ;
      end
      WR_DATA: begin
        axi.WREADY = 1'b1;
        if (axi.WVALID && last_beat) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        axi.BVALID = 1'b1;
        axi.BID    = id_q;
        axi.BRESP  = decerr_q ? 2'b11 : (err_q ? 2'b10 : 2'b00);
        if (axi.BREADY) state_nxt = IDLE;
      end
      RD_REQ: state_nxt = RD_DATA;
      RD_DATA: begin
        axi.RVALID = 1'b1;
        axi.RID    = id_q;
        axi.RDATA  = (in_range && !err_q) ? mem_q : '0;
        axi.RRESP  = !in_range ? 2'b11 : (err_q ? 2'b10 : 2'b00);
        axi.RLAST  = last_beat;
        if (axi.RREADY) state_nxt = last_beat ? IDLE : RD_REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst context: latched on address handshake, advanced per data beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      decerr_q  <= 1'b0;
      last_rd_q <= 1'b1;
    end else begin
      if (aw_go) begin
        id_q     <= axi.AWID;
        addr_q   <= axi.AWADDR[ADDR_WIDTH-1:3];
        len_q    <= axi.AWLEN;
        beat_q   <= '0;
        fixed_q  <= (axi.AWBURST == 2'b00);
        err_q    <= bad_req(axi.AWSIZE, axi.AWBURST);
        decerr_q <= 1'b0;
      end else if (ar_go) begin
        id_q     <= axi.ARID;
        addr_q   <= axi.ARADDR[ADDR_WIDTH-1:3];
        len_q    <= axi.ARLEN;
        beat_q   <= '0;
        fixed_q  <= (axi.ARBURST == 2'b00);
        err_q    <= bad_req(axi.ARSIZE, axi.ARBURST);
        decerr_q <= 1'b0;
      end
      if (w_hs) begin
        beat_q <= beat_q + 8'd1;
        if (!fixed_q) addr_q <= addr_q + WA_W'(1);
        if (!in_range) decerr_q <= 1'b1;
        // WLAST must coincide with the AWLEN-th beat
        if (axi.WLAST != last_beat) err_q <= 1'b1;
      end
      if (state == RD_DATA && axi.RREADY) begin
        beat_q <= beat_q + 8'd1;
        if (!fixed_q) addr_q <= addr_q + WA_W'(1);
        if (last_beat) last_rd_q <= 1'b1;
      end
      if (state == WR_RESP && axi.BREADY) last_rd_q <= 1'b0;
    end
  end

  // Word array: byte-masked writes, registered read; contents survive reset
  always_ff @(posedge clk) begin
    if (w_hs && in_range && !err_q) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (axi.WSTRB[b]) mem[addr_q[IDX_W-1:0]][8*b +: 8] <= axi.WDATA[8*b +: 8];
      end
    end
    if (state == RD_REQ) mem_q <= mem[addr_q[IDX_W-1:0]];
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  localparam int unsigned IDW   = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4096;
  localparam int          LIMIT = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  axi_sram_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_sram_slave #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .axi (axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
    int n;
    axi.AWADDR = addr; axi.AWLEN = len; axi.AWSIZE = size; axi.AWBURST = burst;
    axi.AWID = id; axi.AWVALID = 1'b1;
    for (n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (axi.AWREADY) break;
    end
    chk("aw_timeout", 64'(n < LIMIT), 64'd1);
    @(posedge clk); #1;
    axi.AWVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
    int n;
    axi.ARADDR = addr; axi.ARLEN = len; axi.ARSIZE = size; axi.ARBURST = burst;
    axi.ARID = id; axi.ARVALID = 1'b1;
    for (n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (axi.ARREADY) break;
    end
    chk("ar_timeout", 64'(n < LIMIT), 64'd1);
    @(posedge clk); #1;
    axi.ARVALID = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n;
    axi.WDATA = data; axi.WSTRB = strb; axi.WLAST = last; axi.WVALID = 1'b1;
    for (n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (axi.WREADY) break;
    end
    chk("w_timeout", 64'(n < LIMIT), 64'd1);
    @(posedge clk); #1;
    axi.WVALID = 1'b0;
  endtask

  task automatic b_check(input string tag, input logic [1:0] resp, input logic [3:0] id);
    int n;
    axi.BREADY = 1'b1;
    for (n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (axi.BVALID) break;
    end
    chk({tag, "_btimeout"}, 64'(n < LIMIT), 64'd1);
    chk({tag, "_bresp"}, 64'(axi.BRESP), 64'(resp));
    chk({tag, "_bid"}, 64'(axi.BID), 64'(id));
    @(posedge clk); #1;
    axi.BREADY = 1'b0;
  endtask

  task automatic r_check(input string tag, input logic [63:0] data, input logic [1:0] resp,
                         input logic last, input logic [3:0] id);
    int n;
    axi.RREADY = 1'b1;
    for (n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (axi.RVALID) break;
    end
    chk({tag, "_rtimeout"}, 64'(n < LIMIT), 64'd1);
    chk({tag, "_rdata"}, axi.RDATA, data);
    chk({tag, "_rresp"}, 64'(axi.RRESP), 64'(resp));
    chk({tag, "_rlast"}, 64'(axi.RLAST), 64'(last));
    chk({tag, "_rid"}, 64'(axi.RID), 64'(id));
    @(posedge clk); #1;
    axi.RREADY = 1'b0;
  endtask

  initial begin
    axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0;
    axi.AWVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0;
    axi.BREADY = 1'b0; axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0;
    axi.ARBURST = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b0;

    // Arbitration: both requests pending out of reset
    axi.AWADDR = 32'h0; axi.AWLEN = 8'd0; axi.AWSIZE = 3'd3; axi.AWBURST = 2'b01; axi.AWID = 4'd1;
    axi.AWVALID = 1'b1;
    axi.ARADDR = 32'h0; axi.ARLEN = 8'd0; axi.ARSIZE = 3'd3; axi.ARBURST = 2'b01; axi.ARID = 4'd2;
    axi.ARVALID = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(axi.AWREADY), 64'd0);
    chk("rst_bvalid", 64'(axi.BVALID), 64'd0);
    chk("rst_rvalid", 64'(axi.RVALID), 64'd0);
    chk("rst_wready", 64'(axi.WREADY), 64'd0);
    rst = 1'b0;
    #1;
    chk("arb1_awready", 64'(axi.AWREADY), 64'd1);
    chk("arb1_arready", 64'(axi.ARREADY), 64'd0);
    @(posedge clk); #1;
    axi.AWVALID = 1'b0;
    w_send(64'hD0D0_D0D0_D0D0_D0D0, 8'hFF, 1'b1);
    b_check("arb1", 2'b00, 4'd1);
    axi.AWADDR = 32'h8; axi.AWID = 4'd3; axi.AWVALID = 1'b1;
    #1;
    chk("arb2_arready", 64'(axi.ARREADY), 64'd1);
    chk("arb2_awready", 64'(axi.AWREADY), 64'd0);
    @(posedge clk); #1;
    axi.ARVALID = 1'b0;
    r_check("arb2", 64'hD0D0_D0D0_D0D0_D0D0, 2'b00, 1'b1, 4'd2);
    axi.ARADDR = 32'h8; axi.ARID = 4'd4; axi.ARVALID = 1'b1;
    #1;
    chk("arb3_awready", 64'(axi.AWREADY), 64'd1);
    chk("arb3_arready", 64'(axi.ARREADY), 64'd0);
    @(posedge clk); #1;
    axi.AWVALID = 1'b0;
    w_send(64'hE1E1_E1E1_E1E1_E1E1, 8'hFF, 1'b1);
    b_check("arb3", 2'b00, 4'd3);
    ar_send(32'h8, 8'd0, 3'd3, 2'b01, 4'd4);
    r_check("arb4", 64'hE1E1_E1E1_E1E1_E1E1, 2'b00, 1'b1, 4'd4);

    // Write then read back a 4-beat INCR burst
    aw_send(32'h40, 8'd3, 3'd3, 2'b01, 4'd5);
    w_send(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
    w_send(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
    w_send(64'h3333_3333_3333_3333, 8'hFF, 1'b0);
    w_send(64'h4444_4444_4444_4444, 8'hFF, 1'b1);
    b_check("wr4", 2'b00, 4'd5);
    ar_send(32'h40, 8'd3, 3'd3, 2'b01, 4'd6);
    @(negedge clk);
    chk("rd_lat_rvalid_early", 64'(axi.RVALID), 64'd0);
    r_check("rd4_b0", 64'h1111_1111_1111_1111, 2'b00, 1'b0, 4'd6);
    r_check("rd4_b1", 64'h2222_2222_2222_2222, 2'b00, 1'b0, 4'd6);
    r_check("rd4_b2", 64'h3333_3333_3333_3333, 2'b00, 1'b0, 4'd6);
    r_check("rd4_b3", 64'h4444_4444_4444_4444, 2'b00, 1'b1, 4'd6);

    // Partial strobe on word 0x48
    aw_send(32'h48, 8'd0, 3'd3, 2'b01, 4'd7);
    w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    b_check("preset", 2'b00, 4'd7);
    aw_send(32'h48, 8'd0, 3'd3, 2'b01, 4'd7);
    w_send(64'h0, 8'h0F, 1'b1);
    b_check("strb", 2'b00, 4'd7);
    ar_send(32'h48, 8'd0, 3'd3, 2'b01, 4'd8);
    r_check("strb", 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 4'd8);

    // Burst running off the end of the array
    aw_send(DEPTH * 8 - 8, 8'd1, 3'd3, 2'b01, 4'd9);
    w_send(64'hAAAA_5555_AAAA_5555, 8'hFF, 1'b0);
    w_send(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b1);
    b_check("oob_wr", 2'b11, 4'd9);
    ar_send(DEPTH * 8 - 8, 8'd0, 3'd3, 2'b01, 4'd9);
    r_check("oob_last_word", 64'hAAAA_5555_AAAA_5555, 2'b00, 1'b1, 4'd9);
    ar_send(DEPTH * 8, 8'd0, 3'd3, 2'b01, 4'd9);
    r_check("oob_rd", 64'h0, 2'b11, 1'b1, 4'd9);
    ar_send(32'h0, 8'd0, 3'd3, 2'b01, 4'd9);
    r_check("oob_no_alias", 64'hD0D0_D0D0_D0D0_D0D0, 2'b00, 1'b1, 4'd9);

    // Bad ARSIZE
    ar_send(32'h40, 8'd0, 3'd2, 2'b01, 4'd10);
    r_check("bad_size", 64'h0, 2'b10, 1'b1, 4'd10);

    // Early WLAST
    aw_send(32'h100, 8'd1, 3'd3, 2'b01, 4'd11);
    w_send(64'h1234, 8'hFF, 1'b1);
    w_send(64'h5678, 8'hFF, 1'b1);
    b_check("early_wlast", 2'b10, 4'd11);

    // Read backpressure: RREADY low 5 cycles on beat 1
    ar_send(32'h40, 8'd3, 3'd3, 2'b01, 4'd12);
    r_check("bp_b0", 64'h1111_1111_1111_1111, 2'b00, 1'b0, 4'd12);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_rvalid", 64'(axi.RVALID), 64'd1);
      chk("bp_hold_rdata", axi.RDATA, 64'hFFFF_FFFF_0000_0000);
      chk("bp_hold_rlast", 64'(axi.RLAST), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    r_check("bp_b1", 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b0, 4'd12);
    r_check("bp_b2", 64'h3333_3333_3333_3333, 2'b00, 1'b0, 4'd12);
    r_check("bp_b3", 64'h4444_4444_4444_4444, 2'b00, 1'b1, 4'd12);

    // Write response backpressure: BREADY low 3 cycles
    aw_send(32'h200, 8'd0, 3'd3, 2'b01, 4'd13);
    w_send(64'hC3C3_C3C3_C3C3_C3C3, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bbp_hold_bvalid", 64'(axi.BVALID), 64'd1);
      chk("bbp_hold_bresp", 64'(axi.BRESP), 64'd0);
    end
    @(posedge clk); #1;
    b_check("bbp", 2'b00, 4'd13);

    // Reset in the middle of an 8-beat read
    ar_send(32'h40, 8'd7, 3'd3, 2'b01, 4'd14);
    r_check("rst_rd_b0", 64'h1111_1111_1111_1111, 2'b00, 1'b0, 4'd14);
    repeat (2) @(negedge clk);
    chk("rst_rd_pre_rvalid", 64'(axi.RVALID), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_rd_rvalid", 64'(axi.RVALID), 64'd0);
    chk("rst_rd_rdata", axi.RDATA, 64'h0);
    chk("rst_rd_rlast", 64'(axi.RLAST), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rvalid", 64'(axi.RVALID), 64'd0);
    ar_send(32'h40, 8'd1, 3'd3, 2'b01, 4'd15);
    r_check("post_rst_b0", 64'h1111_1111_1111_1111, 2'b00, 1'b0, 4'd15);
    r_check("post_rst_b1", 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 4'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
